muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer.sv | 141 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - RV32M iterative multiply/divide sequencer
// One radix-2 step per cycle on a shared adder: shift-add multiply, restoring divide.
module muldiv_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [2:0]  Funct3,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Result
);

  typedef enum logic [1:0] {IDLE, ITER, FINISH} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic [2:0]  f3_q;
  logic        sa_q, sb_q;
  logic [31:0] hi_q, lo_q, opb_q;
  logic        busy_q, done_q;
  logic [31:0] result_q;

  logic [31:0] hi_d, lo_d;
  logic [32:0] add_a, add_b, add_y;
  logic        a_signed, b_signed, neg_a, neg_b;
  logic [31:0] abs_a, abs_b;
  logic [63:0] prod, prod_s;
  logic [31:0] quot_s, rem_s, fin_result;

  assign a_signed = (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                    (Funct3 == 3'b100) || (Funct3 == 3'b110);
  assign b_signed = (Funct3 == 3'b001) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
  assign neg_a    = a_signed & SrcA[31];
  assign neg_b    = b_signed & SrcB[31];
  assign abs_a    = neg_a ? -SrcA : SrcA;
  assign abs_b    = neg_b ? -SrcB : SrcB;

  // Divide feeds the shifted partial remainder (33 bits) into the same adder.
  assign add_a = f3_q[2] ? {hi_q, lo_q[31]} : {1'b0, hi_q};
  assign add_b = {1'b0, opb_q};
  assign add_y = f3_q[2] ? (add_a - add_b) : (add_a + add_b);

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (f3_q[2]) begin
      if (!add_y[32]) begin
        hi_d = add_y[31:0];
        lo_d = {lo_q[30:0], 1'b1};
      end else begin
        hi_d = add_a[31:0];
        lo_d = {lo_q[30:0], 1'b0};
      end
    end else if (lo_q[0]) begin
      {hi_d, lo_d} = {add_y, lo_q[31:1]};
    end else begin
      {hi_d, lo_d} = {1'b0, hi_q, lo_q[31:1]};
    end
  end

  assign prod   = {hi_q, lo_q};
  assign prod_s = (sa_q ^ sb_q) ? -prod : prod;
  assign quot_s = (sa_q ^ sb_q) ? -lo_q : lo_q;
  assign rem_s  = sa_q ? -hi_q : hi_q;

  always_comb begin
    fin_result = rem_s;
    case (f3_q)
      3'b000:                 fin_result = prod_s[31:0];
      3'b001, 3'b010, 3'b011: fin_result = prod_s[63:32];
      3'b100, 3'b101:         fin_result = quot_s;
      default:                fin_result = rem_s;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      f3_q     <= 3'd0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      opb_q    <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (Start) begin
            f3_q   <= Funct3;
            cnt_q  <= 5'd0;
            busy_q <= 1'b1;
            // Divide by zero: preset quotient all-ones and remainder = raw dividend.
            if (Funct3[2] && (SrcB == 32'd0)) begin
              sa_q    <= 1'b0;
              sb_q    <= 1'b0;
              hi_q    <= SrcA;
              lo_q    <= 32'hFFFF_FFFF;
              opb_q   <= 32'd0;
              state_q <= FINISH;
            end else begin
              sa_q    <= neg_a;
              sb_q    <= neg_b;
              hi_q    <= 32'd0;
              lo_q    <= Funct3[2] ? abs_a : abs_b;
              opb_q   <= Funct3[2] ? abs_b : abs_a;
              state_q <= ITER;
            end
          end
        end
        ITER: begin
          hi_q <= hi_d;
          lo_q <= lo_d;
          if (cnt_q == 5'd31) begin
            state_q <= FINISH;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        FINISH: begin
          result_q <= fin_result;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer
// Arithmetic reference model plus directed literal cases and randomized traffic.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [2:0]  Funct3;
  logic [31:0] SrcA, SrcB;
  logic        Busy, Done;
  logic [31:0] Result;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer dut (
    .clk(clk), .reset(reset), .Start(Start), .Funct3(Funct3),
    .SrcA(SrcA), .SrcB(SrcB), .Busy(Busy), .Done(Done), .Result(Result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p = 64'd0;
    case (f)
      3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'd0, b}); return p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Timing model: an accepted op occupies the unit for a fixed number of edges.
  int          busy_left = 0;
  bit          exp_done = 1'b0;
  logic [31:0] exp_res = 32'd0;
  logic [31:0] pend_res = 32'd0;
  bit          armed = 1'b0;

  always @(posedge clk) begin
    armed = 1'b1;
    if (reset) begin
      busy_left = 0;
      exp_done  = 1'b0;
      exp_res   = 32'd0;
    end else begin
      exp_done = 1'b0;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          exp_done = 1'b1;
          exp_res  = pend_res;
        end
      end else if (Start) begin
        pend_res  = ref_op(Funct3, SrcA, SrcB);
        busy_left = (Funct3[2] && SrcB == 32'd0) ? 1 : 33;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      checks++;
      if (Busy !== (busy_left > 0)) begin
        errors++;
        $display("FAIL busy t=%0t actual=%b required=%b", $time, Busy, busy_left > 0);
      end
      checks++;
      if (Done !== exp_done) begin
        errors++;
        $display("FAIL done t=%0t actual=%b required=%b", $time, Done, exp_done);
      end
      checks++;
      if (Result !== exp_res) begin
        errors++;
        $display("FAIL result t=%0t actual=%h required=%h", $time, Result, exp_res);
      end
    end
  end

  task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((Busy || Done) && n < 80) begin
      @(negedge clk);
      n++;
    end
    expect_eq("wait_idle", {31'd0, Busy}, 32'd0);
  endtask

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expv, input int exp_lat, input string name);
    int lat, busy_n;
    bit seen;
    @(negedge clk);
    Start = 1'b1; Funct3 = f; SrcA = a; SrcB = b;
    lat = 0; busy_n = 0; seen = 1'b0;
    while (!seen && lat < 60) begin
      @(negedge clk);
      lat++;
      Start  = (lat < exp_lat) ? 1'($urandom) : 1'b0;
      Funct3 = 3'($urandom);
      SrcA   = $urandom;
      SrcB   = $urandom;
      if (Busy) busy_n++;
      if (Done) seen = 1'b1;
    end
    Start = 1'b0;
    expect_eq({name, "_seen"}, {31'd0, seen}, 32'd1);
    expect_eq({name, "_val"}, Result, expv);
    expect_eq({name, "_lat"}, lat, exp_lat);
    expect_eq({name, "_busy"}, busy_n, exp_lat - 1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dones;
    reset = 1'b1; Start = 1'b0; Funct3 = 3'd0; SrcA = 32'd0; SrcB = 32'd0;
    repeat (3) @(negedge clk);
    expect_eq("reset_result", Result, 32'd0);
    expect_eq("reset_busy", {30'd0, Busy, Done}, 32'd0);
    reset = 1'b0;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul_7_m3");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34, "mulh");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mulhsu");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div_m7_2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem_m7_2");
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 34, "divu_100_7");
    run_op(3'd7, 32'd100, 32'd7, 32'd2, 34, "remu_100_7");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, "rem_ovf");
    run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, "divu_by0");
    run_op(3'd7, 32'd5, 32'd0, 32'd5, 2, "remu_by0");
    run_op(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 2, "div_by0");
    run_op(3'd6, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 2, "rem_by0");
    wait_idle();

    // Abort mid-iteration with reset.
    @(negedge clk);
    Start = 1'b1; Funct3 = 3'd0; SrcA = 32'd9; SrcB = 32'd9;
    @(negedge clk);
    Start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    expect_eq("abort_busy", {31'd0, Busy}, 32'd0);
    expect_eq("abort_result", Result, 32'd0);
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (Done) dones++;
    end
    expect_eq("abort_no_done", dones, 0);
    run_op(3'd0, 32'd3, 32'd4, 32'd12, 34, "mul_3_4");
    wait_idle();

    // Start held high with a toggling SrcA.
    @(negedge clk);
    Start = 1'b1; Funct3 = 3'd0; SrcA = 32'd6; SrcB = 32'd5;
    dones = 0;
    for (int i = 1; i <= 34; i++) begin
      @(negedge clk);
      SrcA = ~SrcA;
      if (Done) begin
        dones++;
        expect_eq("held_start_val", Result, 32'd30);
      end
    end
    expect_eq("held_start_dones", dones, 1);
    @(negedge clk);
    Start = 1'b0;
    expect_eq("held_start_restart", {31'd0, Busy}, 32'd1);
    wait_idle();

    // Randomized traffic, checked cycle by cycle against the model.
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      reset  = (($urandom % 1500) == 0);
      Start  = (($urandom % 3) == 0);
      Funct3 = 3'($urandom);
      SrcA   = pick();
      SrcB   = pick();
    end
    reset = 1'b0; Start = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
